step_run_controller: RTL and testbench

Sequences processor execution from front-panel button pulses: one instruction per Step press, or free-running at a divided rate under Run. It drives the processor's clock-enable. It accepts only single-cycle, already-synchronized pulses from the board button synchronizers, and it stops when the processor reports a halt. It sits between the button synchronizers and the CPU datapath enable, and exports run/halt status and an executed-instruction count for the display.

---
 rtl/step_run_controller.sv | 79 +++++++
 tb/tb_step_run_controller.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/step_run_controller.sv
// rtl/step_run_controller.sv - front-panel step/run sequencer driving the CPU clock-enable
module step_run_controller #(
    parameter int RUN_DIV = 4,
    parameter int CNT_W   = 16
) (
    input  logic             Clk,
    input  logic             ResetN,
    input  logic             StepP,
    input  logic             RunP,
    input  logic             ClearP,
    input  logic             HaltIn,
    output logic             CpuEn,
    output logic             Running,
    output logic             Halted,
    output logic [CNT_W-1:0] StepCount
);

    localparam int PRE_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(RUN_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'h0,
        S_STEP = 2'h1,
        S_RUN  = 2'h2,
        S_HALT = 2'h3
    } state_t;

    state_t           state, state_next;
    logic [PRE_W-1:0] pre, pre_next;

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state     <= S_IDLE;
            pre       <= '0;
            StepCount <= '0;
        end else begin
            state <= state_next;
            pre   <= pre_next;
            if (ClearP)
                StepCount <= '0;
            else if (CpuEn)
                StepCount <= StepCount + CNT_W'(1);
        end
    end

    always_comb begin
        state_next = state;
        if (ClearP) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (HaltIn)     state_next = S_HALT;
                    else if (RunP)  state_next = S_RUN;
                    else if (StepP) state_next = S_STEP;
                end
                S_STEP:  state_next = HaltIn ? S_HALT : S_IDLE;
                S_RUN: begin
                    if (HaltIn)    state_next = S_HALT;
                    else if (RunP) state_next = S_IDLE;
                end
                S_HALT:  state_next = S_HALT;
                default: state_next = S_IDLE;
            endcase
        end

        // Prescaler only advances while staying in Run; any exit or entry restarts it at zero.
        pre_next = '0;
        if (state == S_RUN && state_next == S_RUN)
            pre_next = (pre == PRE_LAST) ? '0 : pre + PRE_W'(1);
    end

    always_comb begin
        CpuEn   = (state == S_STEP) || ((state == S_RUN) && (pre == PRE_LAST));
        Running = (state == S_RUN);
        Halted  = (state == S_HALT);
    end

endmodule

// File: tb/tb_step_run_controller.sv
// tb/tb_step_run_controller.sv - directed self-checking bench for step_run_controller
module tb_step_run_controller;

    logic        Clk;
    logic        ResetN;
    logic        StepP, RunP, ClearP, HaltIn;
    logic        en4, run4, hlt4;
    logic [15:0] cnt4;
    logic        en1, run1, hlt1;
    logic [3:0]  cnt1;

    int checks   = 0;
    int failures = 0;
    int exp_cnt;

    step_run_controller #(.RUN_DIV(4), .CNT_W(16)) dut4 (
        .Clk(Clk), .ResetN(ResetN), .StepP(StepP), .RunP(RunP), .ClearP(ClearP),
        .HaltIn(HaltIn), .CpuEn(en4), .Running(run4), .Halted(hlt4), .StepCount(cnt4)
    );

    step_run_controller #(.RUN_DIV(1), .CNT_W(4)) dut1 (
        .Clk(Clk), .ResetN(ResetN), .StepP(StepP), .RunP(RunP), .ClearP(ClearP),
        .HaltIn(HaltIn), .CpuEn(en1), .Running(run1), .Halted(hlt1), .StepCount(cnt1)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_inputs;
        StepP  = 1'b0;
        RunP   = 1'b0;
        ClearP = 1'b0;
        HaltIn = 1'b0;
    endtask

    initial begin
        idle_inputs();
        ResetN = 1'b1;
        #1 ResetN = 1'b0;
        #1;
        check("rst_en",   32'(en4),  32'd0);
        check("rst_run",  32'(run4), 32'd0);
        check("rst_halt", 32'(hlt4), 32'd0);
        check("rst_cnt",  32'(cnt4), 32'd0);
        tick();
        tick();
        ResetN = 1'b1;

        // single step: StepP in cycle 5
        for (int c = 0; c <= 8; c++) begin
            idle_inputs();
            StepP = (c == 5);
            check("t1_en",   32'(en4),  32'(c == 6));
            check("t1_cnt",  32'(cnt4), (c >= 7) ? 32'd1 : 32'd0);
            check("t1_run",  32'(run4), 32'd0);
            check("t1_halt", 32'(hlt4), 32'd0);
            tick();
        end

        // run and stop: RunP in 0 and 13, stray StepP in 6
        idle_inputs();
        ClearP = 1'b1;
        tick();
        exp_cnt = 0;
        for (int c = 0; c <= 15; c++) begin
            logic e;
            idle_inputs();
            RunP  = (c == 0 || c == 13);
            StepP = (c == 6);
            e = (c == 4 || c == 8 || c == 12);
            check("t2_en",  32'(en4),  32'(e));
            check("t2_run", 32'(run4), 32'(c >= 1 && c <= 13));
            check("t2_cnt", 32'(cnt4), 32'(exp_cnt));
            if (e) exp_cnt++;
            tick();
        end
        check("t2_final", 32'(cnt4), 32'd3);

        // halt collides with an enable, then is ignored until clear
        for (int c = 0; c <= 11; c++) begin
            logic e;
            idle_inputs();
            RunP   = (c == 0 || c == 6);
            HaltIn = (c >= 4 && c < 7);
            StepP  = (c == 5 || c == 8);
            ClearP = (c == 10);
            e = (c == 4);
            check("t3_en",   32'(en4),  32'(e));
            check("t3_run",  32'(run4), 32'(c >= 1 && c <= 4));
            check("t3_halt", 32'(hlt4), 32'(c >= 5 && c <= 10));
            check("t3_cnt",  32'(cnt4), 32'(exp_cnt));
            if (ClearP) exp_cnt = 0;
            else if (e) exp_cnt++;
            tick();
        end

        // priority: step+run, clear+halt, dropped step, clear during step
        for (int c = 0; c <= 6; c++) begin
            logic e;
            idle_inputs();
            StepP  = (c == 0 || c == 2 || c == 3 || c == 4);
            RunP   = (c == 0);
            ClearP = (c == 1 || c == 5);
            HaltIn = (c == 1);
            e = (c == 3 || c == 5);
            check("t4_en",   32'(en4),  32'(e));
            check("t4_run",  32'(run4), 32'(c == 1));
            check("t4_halt", 32'(hlt4), 32'd0);
            check("t4_cnt",  32'(cnt4), 32'(exp_cnt));
            if (ClearP) exp_cnt = 0;
            else if (e) exp_cnt++;
            tick();
        end

        // counter wrap with RUN_DIV = 1, CNT_W = 4
        idle_inputs();
        ClearP = 1'b1;
        tick();
        exp_cnt = 0;
        for (int c = 0; c <= 18; c++) begin
            idle_inputs();
            RunP = (c == 0);
            check("t5_en",  32'(en1),  32'(c >= 1));
            check("t5_run", 32'(run1), 32'(c >= 1));
            check("t5_cnt", 32'(cnt1), 32'(exp_cnt));
            if (c >= 1) exp_cnt = (exp_cnt + 1) % 16;
            tick();
        end
        check("t5_pre_rst", 32'(cnt1), 32'd2);

        // asynchronous reset in mid-cycle
        #3 ResetN = 1'b0;
        #1;
        check("ar_en",   32'(en1),  32'd0);
        check("ar_run",  32'(run1), 32'd0);
        check("ar_halt", 32'(hlt1), 32'd0);
        check("ar_cnt",  32'(cnt1), 32'd0);
        check("ar_run4", 32'(run4), 32'd0);
        check("ar_cnt4", 32'(cnt4), 32'd0);
        tick();
        ResetN = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
